// File: rtl/pc_sequencer.sv
// Fetch-side architectural state for the single-cycle core: program counter,
// N/Z/V flags, run/halt control and a saturating retired-instruction count.
module pc_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            fetch_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  input  logic            instr_vld,
  input  logic            hlt,
  input  logic            alt_pc_ctrl,
  input  logic [PC_W-1:0] alt_pc,
  input  logic            flag_we,
  input  logic            alu_n,
  input  logic            alu_z,
  input  logic            alu_v,
  output logic            n_flag,
  output logic            z_flag,
  output logic            v_flag,
  output logic            wb_en,
  output logic            halted,
  output logic [PC_W-1:0] retired,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            run;
  logic            commit;
  logic            halt_req;
  logic [PC_W-1:0] pc_nxt;

  // Fetch handshake: fetch_req is high for the whole of RUN, presenting pc;
  // an instruction is consumed only in a cycle where instr_vld is also high.
  // A low instr_vld is a wait state of any length and changes nothing.
  assign run       = (state == RUN);
  assign fetch_req = run;
  assign commit    = run & instr_vld & ~hlt;
  assign halt_req  = run & instr_vld & hlt;
  assign wb_en     = commit;
  assign halted    = (state == HALT);
  assign fsm_state = state;
  assign pc_plus1  = pc + PC_W'(1);

  // Select is a clean 0 whenever the branch is not taken, so alt_pc never leaks.
  assign pc_nxt = alt_pc_ctrl ? alt_pc : pc_plus1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt_req) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      n_flag  <= 1'b0;
      z_flag  <= 1'b0;
      v_flag  <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (commit) begin
        pc <= pc_nxt;
        if (flag_we) begin
          n_flag <= alu_n;
          z_flag <= alu_z;
          v_flag <= alu_v;
        end
        if (retired != '1) retired <= retired + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural model of fetch state checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_pc_sequencer;

  localparam int PC_W = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic            fetch_req;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic            instr_vld;
  logic            hlt;
  logic            alt_pc_ctrl;
  logic [PC_W-1:0] alt_pc;
  logic            flag_we;
  logic            alu_n, alu_z, alu_v;
  logic            n_flag, z_flag, v_flag;
  logic            wb_en;
  logic            halted;
  logic [PC_W-1:0] retired;
  logic [1:0]      fsm_state;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .fetch_req(fetch_req), .pc(pc),
    .pc_plus1(pc_plus1), .instr_vld(instr_vld), .hlt(hlt),
    .alt_pc_ctrl(alt_pc_ctrl), .alt_pc(alt_pc), .flag_we(flag_we),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .n_flag(n_flag),
    .z_flag(z_flag), .v_flag(v_flag), .wb_en(wb_en), .halted(halted),
    .retired(retired), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: mode 0 idle, 1 running, 2 halted
  int              m_mode;
  logic [PC_W-1:0] m_pc;
  logic [2:0]      m_nzv;
  int              m_ret;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_pc   <= 16'h0000;
      m_nzv  <= 3'b000;
      m_ret  <= 0;
    end else if (m_mode == 0) begin
      if (start) m_mode <= 1;
    end else if (m_mode == 1 && instr_vld) begin
      if (hlt) m_mode <= 2;
      else begin
        m_pc  <= alt_pc_ctrl ? alt_pc : PC_W'((int'(m_pc) + 1) % 65536);
        if (flag_we) m_nzv <= {alu_n, alu_z, alu_v};
        m_ret <= (m_ret == 65535) ? 65535 : m_ret + 1;
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    chk("fetch_req", {31'd0, fetch_req}, {31'd0, m_mode == 1});
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("pc_plus1", {16'd0, pc_plus1}, (int'(m_pc) + 1) % 65536);
    chk("wb_en", {31'd0, wb_en}, {31'd0, (m_mode == 1) && instr_vld && !hlt});
    chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
    chk("flags", {29'd0, n_flag, z_flag, v_flag}, {29'd0, m_nzv});
    chk("retired", {16'd0, retired}, m_ret);
  end

  // driver: inputs change 1 time unit after the rising edge
  task automatic drive(input logic vld, input logic h, input logic ctrl,
                       input logic [PC_W-1:0] apc, input logic fwe, input logic [2:0] nzv);
    instr_vld   = vld;
    hlt         = h;
    alt_pc_ctrl = ctrl;
    alt_pc      = apc;
    flag_we     = fwe;
    {alu_n, alu_z, alu_v} = nzv;
    @(posedge clk);
    #1;
  endtask

  task automatic commit_seq(input logic ctrl, input logic [PC_W-1:0] apc);
    drive(1'b1, 1'b0, ctrl, apc, 1'b0, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    instr_vld = 1'b0; hlt = 1'b0; alt_pc_ctrl = 1'b0; alt_pc = '0;
    flag_we = 1'b0; alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset: start is the only way out
    repeat (5) drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'b111);
    chk("lit_idle_pc", {16'd0, pc}, 32'h0000);
    chk("lit_idle_fetch", {31'd0, fetch_req}, 32'd0);
    chk("lit_idle_halted", {31'd0, halted}, 32'd0);
    chk("lit_idle_retired", {16'd0, retired}, 32'd0);

    start = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);
    start = 1'b0;
    chk("lit_run_fetch", {31'd0, fetch_req}, 32'd1);

    // sequential fetch
    repeat (3) commit_seq(1'b0, 16'h0000);
    chk("lit_seq_pc", {16'd0, pc}, 32'h0003);
    chk("lit_seq_retired", {16'd0, retired}, 32'd3);

    // branch at 0005, then not-taken with X target
    repeat (2) commit_seq(1'b0, 16'h1234);
    chk("lit_pc5", {16'd0, pc}, 32'h0005);
    commit_seq(1'b1, 16'h0040);
    chk("lit_branch", {16'd0, pc}, 32'h0040);
    commit_seq(1'b0, 'x);
    chk("lit_no_x", {16'd0, pc}, 32'h0041);

    // wait states at 0010; other inputs must be ignored
    commit_seq(1'b1, 16'h0010);
    repeat (4) drive(1'b0, 1'b1, 1'b1, 16'h0bad, 1'b1, 3'b111);
    chk("lit_wait_pc", {16'd0, pc}, 32'h0010);
    chk("lit_wait_retired", {16'd0, retired}, 32'd8);
    commit_seq(1'b0, 16'h0000);
    chk("lit_wait_resume", {16'd0, pc}, 32'h0011);

    // flags: written only with flag_we
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'b010);
    chk("lit_z_set", {31'd0, z_flag}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);
    chk("lit_z_hold", {31'd0, z_flag}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'b101);
    chk("lit_nzv", {29'd0, n_flag, z_flag, v_flag}, 32'b101);

    // wrap from all-ones
    commit_seq(1'b1, 16'hffff);
    chk("lit_plus1_wrap", {16'd0, pc_plus1}, 32'h0000);
    commit_seq(1'b0, 16'h0000);
    chk("lit_wrap_pc", {16'd0, pc}, 32'h0000);

    // halt beats branch and flag write
    commit_seq(1'b1, 16'h0020);
    drive(1'b1, 1'b1, 1'b1, 16'h0099, 1'b1, 3'b010);
    chk("lit_halted", {31'd0, halted}, 32'd1);
    chk("lit_halt_pc", {16'd0, pc}, 32'h0020);
    chk("lit_halt_retired", {16'd0, retired}, 32'd15);
    chk("lit_halt_flags", {29'd0, n_flag, z_flag, v_flag}, 32'b101);
    start = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);
    start = 1'b0;
    chk("lit_halt_sticky", {31'd0, halted}, 32'd1);

    // asynchronous reset from HALT, mid-cycle
    rst = 1'b1;
    #2;
    chk("lit_arst_pc", {16'd0, pc}, 32'h0000);
    chk("lit_arst_halted", {31'd0, halted}, 32'd0);
    chk("lit_arst_fetch", {31'd0, fetch_req}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);

    // restart, run, then reset mid-run
    start = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);
    start = 1'b0;
    commit_seq(1'b1, 16'h0300);
    commit_seq(1'b0, 16'h0000);
    chk("lit_rerun_pc", {16'd0, pc}, 32'h0301);
    rst = 1'b1;
    #2;
    chk("lit_mid_rst_pc", {16'd0, pc}, 32'h0000);
    chk("lit_mid_rst_retired", {16'd0, retired}, 32'd0);
    rst = 1'b0;
    repeat (2) drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);

    $display("final fsm_state %0d", fsm_state);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns architectural fetch state for the single-cycle core: program counter, N/Z/V flag register, run/halt control.
Consumes decode outputs (alt_pc, alt_pc_ctrl, hlt) and ALU flag results. Feeds PC to instruction memory and registered flags back to decode.
Instruction memory may insert wait cycles via a valid handshake. Gates register-file write-back so only committed instructions update state.

Parameters:
PC_W, 16, width of PC, alt_pc and retired counter
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; moves IDLE to RUN
fetch_req  output  1  high while requesting instruction at pc
pc  output  PC_W  address of current instruction
pc_plus1  output  PC_W  pc+1, mod 2^PC_W; used for jal link value
instr_vld  input  1  instruction memory returns valid instruction for pc this cycle
hlt  input  1  decode: current instruction is halt
alt_pc_ctrl  input  1  decode: take alt_pc as next PC
alt_pc  input  PC_W  decode: branch/jal/jr target; may be X when alt_pc_ctrl=0
flag_we  input  1  current instruction updates flags (add/addz/sub/and/nor/shift ops)
alu_n, alu_z, alu_v  input  1 each  flag results from ALU this cycle
n_flag, z_flag, v_flag  output  1 each  registered flags to decode
wb_en  output  1  commit strobe; register-file write = decode we AND wb_en
halted  output  1  high in HALT
retired  output  PC_W  count of committed instructions, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, n/z/v=0, retired=0. All outputs derive from this state: fetch_req=0, wb_en=0, halted=0.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: see commit rules below.
  - HALT: terminal until rst. start ignored in HALT and RUN.
- fetch_req = (state==RUN), combinational from state.
- commit = RUN & instr_vld & ~hlt, combinational. wb_en = commit.
- On a commit edge:
  - pc <= alt_pc_ctrl ? alt_pc : pc+1.
  - If flag_we: {n,z,v} <= {alu_n,alu_z,alu_v}.
  - retired <= retired+1, saturating at all-ones.
- RUN & instr_vld & hlt: state <= HALT. pc, flags and retired hold. wb_en=0.
- hlt has priority over alt_pc_ctrl and flag_we.
- RUN & ~instr_vld (wait state): no state change, wb_en=0. Wait states are unbounded.
- Flag latency: flags are registered, so they are visible to decode one cycle after the producing commit. A branch immediately following an ALU op sees the new flags.
- Wrap: pc+1 from all-ones gives 0. alt_pc is used verbatim.
- X safety: alt_pc must not propagate when alt_pc_ctrl=0. Inputs other than instr_vld/start are ignored outside RUN-with-instr_vld.
- rst asserted mid-RUN or in HALT: immediate return to reset values, regardless of clock.
- Latency: one instruction per cycle when instr_vld is held high.

Test Plan:
- rst pulse, then idle 5 cycles -> pc=0000, fetch_req=0, halted=0, retired=0. Pulse start -> fetch_req=1 next cycle.
- RUN, instr_vld=1 for 3 cycles, alt_pc_ctrl=0 -> pc 0000,0001,0002,0003; wb_en=1 each cycle; retired=3.
- At pc=0005: alt_pc_ctrl=1, alt_pc=0040 -> next pc=0040. Next cycle, alt_pc_ctrl=0 with alt_pc=X -> pc=0041, no X on pc.
- instr_vld low 4 cycles at pc=0010 -> pc holds 0010, wb_en=0, retired unchanged. Then instr_vld=1 -> pc=0011.
- Flags: flag_we=1, alu_z=1 at commit -> z_flag=1 next cycle. Next commit with flag_we=0, alu_z=0 -> z_flag stays 1.
- hlt=1 with alt_pc_ctrl=1 at pc=0020 -> halted=1, pc=0020, wb_en=0. start ignored. rst -> pc=0000, IDLE.
- PC_W=16, pc=FFFF commit, no branch -> pc=0000.
